// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared definitions for the FFT output reorder buffer: word sizes, read FSM
// encoding and the bit-reversal index helper.
package fft_bitrev_reorder_pkg;

   localparam int FLOAT_LEN_DEF = 32;
   localparam int ADDR_LEN_DEF  = 13;
   localparam int CPLX_LEN_DEF  = 2 * FLOAT_LEN_DEF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } rd_state_t;

   // Reverses the low 'len' bits of 'value'; bits at and above 'len' come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int len);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < len; i++) begin
         r[i] = value[len - 1 - i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Valid-only complex sample stream into and out of the reorder buffer.
interface fft_bitrev_reorder_if
   import fft_bitrev_reorder_pkg::*;
#(
   parameter int FLOAT_LEN = FLOAT_LEN_DEF
);
   logic [2*FLOAT_LEN-1:0] data_in;
   logic                   data_in_valid;
   logic [2*FLOAT_LEN-1:0] data_out;
   logic                   data_out_valid;
   logic                   frame_start;
   logic                   busy;

   modport master (
      output data_in, data_in_valid,
      input  data_out, data_out_valid, frame_start, busy
   );

   modport slave (
      input  data_in, data_in_valid,
      output data_out, data_out_valid, frame_start, busy
   );
endinterface

// File: rtl/fft_bitrev_reorder_dp_ram_sync.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module dp_ram_sync #(
   parameter int WIDTH = 64,
   parameter int AW    = 14
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
   logic [WIDTH-1:0] r_rd_data;

   // Write port
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Registered read port; holds its last word while no read is issued
   always_ff @(posedge clk) begin
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed order and leave in
// natural order, one bank filling while the other drains.
module fft_bitrev_reorder
   import fft_bitrev_reorder_pkg::*;
#(
   parameter int FLOAT_LEN = FLOAT_LEN_DEF,
   parameter int ADDR_LEN  = ADDR_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   fft_bitrev_reorder_if.slave  io_strm
);

   localparam int W = 2 * FLOAT_LEN;
   localparam logic [ADDR_LEN-1:0] LAST_IDX = {ADDR_LEN{1'b1}};

   logic [ADDR_LEN-1:0] r_wr_cnt;
   logic                r_wr_bank;
   logic [1:0]          r_bank_full;
   rd_state_t           r_state;
   logic [ADDR_LEN-1:0] r_rd_cnt;
   logic                r_rd_bank;
   logic                r_rd_vld;
   logic                r_rd_fs;
   logic [W-1:0]        r_data_out;
   logic                r_data_out_vld;
   logic                r_frame_start;

   logic                w_rd_issue;
   logic                w_rd_release;
   logic                w_wr_ok;
   logic                w_wr_en;
   logic                w_wr_last;
   logic [ADDR_LEN-1:0] w_wr_idx;
   logic [1:0]          w_full_set;
   logic [1:0]          w_full_clr;
   logic                w_oth_bank;
   logic                w_next_full;
   logic [W-1:0]        w_ram_q;

   assign w_rd_issue   = (r_state == ST_READ);
   assign w_rd_release = w_rd_issue && (r_rd_cnt == LAST_IDX);

   // A full bank may be refilled on the very edge the reader issues its last address.
   assign w_wr_ok   = !r_bank_full[r_wr_bank] || (w_rd_release && (r_rd_bank == r_wr_bank));
   assign w_wr_en   = io_strm.data_in_valid && w_wr_ok;
   assign w_wr_last = w_wr_en && (r_wr_cnt == LAST_IDX);
   assign w_wr_idx  = ADDR_LEN'(bitrev(32'(r_wr_cnt), ADDR_LEN));

   assign w_oth_bank  = ~r_rd_bank;
   assign w_next_full = r_bank_full[w_oth_bank] || w_full_set[w_oth_bank];

   // Per-bank set/clear requests from the write and read sides
   always_comb begin
      w_full_set = 2'b00;
      w_full_clr = 2'b00;
      if (w_wr_last) begin
         w_full_set[r_wr_bank] = 1'b1;
      end else begin
         w_full_set = 2'b00;
      end
      if (w_rd_release) begin
         w_full_clr[r_rd_bank] = 1'b1;
      end else begin
         w_full_clr = 2'b00;
      end
   end

   dp_ram_sync #(
      .WIDTH (W),
      .AW    (ADDR_LEN + 1)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr ({r_wr_bank, w_wr_idx}),
      .i_wr_data (io_strm.data_in),
      .i_rd_en   (w_rd_issue),
      .i_rd_addr ({r_rd_bank, r_rd_cnt}),
      .o_rd_data (w_ram_q)
   );

   // Write-side sample counter and bank pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_cnt  <= '0;
         r_wr_bank <= 1'b0;
      end else if (w_wr_en) begin
         if (w_wr_last) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= ~r_wr_bank;
         end else begin
            r_wr_cnt  <= r_wr_cnt + 1'b1;
         end
      end
   end

   // Bank occupancy flags; set and clear on different banks both land
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bank_full <= 2'b00;
      end else begin
         r_bank_full <= (r_bank_full & ~w_full_clr) | w_full_set;
      end
   end

   // Read FSM with its issue-stage valid and frame-start flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_rd_cnt  <= '0;
         r_rd_bank <= 1'b0;
         r_rd_vld  <= 1'b0;
         r_rd_fs   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_rd_vld <= 1'b0;
               r_rd_fs  <= 1'b0;
               if (r_bank_full[r_rd_bank]) begin
                  r_state  <= ST_READ;
                  r_rd_cnt <= '0;
               end
            end
            ST_READ: begin
               r_rd_vld <= 1'b1;
               r_rd_fs  <= (r_rd_cnt == '0);
               if (r_rd_cnt == LAST_IDX) begin
                  r_rd_cnt  <= '0;
                  r_rd_bank <= ~r_rd_bank;
                  if (!w_next_full) begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_rd_cnt <= r_rd_cnt + 1'b1;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_rd_cnt <= '0;
               r_rd_vld <= 1'b0;
               r_rd_fs  <= 1'b0;
            end
         endcase
      end
   end

   // Output register; data is forced to zero outside valid samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_out     <= '0;
         r_data_out_vld <= 1'b0;
         r_frame_start  <= 1'b0;
      end else begin
         r_data_out     <= r_rd_vld ? w_ram_q : '0;
         r_data_out_vld <= r_rd_vld;
         r_frame_start  <= r_rd_fs;
      end
   end

   assign io_strm.data_out       = r_data_out;
   assign io_strm.data_out_valid = r_data_out_vld;
   assign io_strm.frame_start    = r_frame_start;
   // A partially written frame also counts as held data
   assign io_strm.busy = (|r_bank_full) || (r_wr_cnt != '0) || w_rd_issue
                         || r_rd_vld || r_data_out_vld;

endmodule
